// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, data width and baud-divider helpers.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

    function automatic logic is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: o_tick is high for the last cycle of each CLKS_PER_BIT window.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == LAST);
    assign o_tick = w_last;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with an inline byte FIFO in front of the serialiser.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    if (CPB < 2) begin : g_bad_cpb
        $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
    end
    if (FIFO_DEPTH < 2 || !is_pow2(FIFO_DEPTH)) begin : g_bad_depth
        $error("uart_tx: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    uart_state_e          r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [BIT_W-1:0]     r_bit;
    logic                 r_tx;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_nempty;
    logic                 w_tick;
    logic [DATA_BITS-1:0] w_head;

    assign ready    = (r_count < CNT_W'(FIFO_DEPTH));
    assign w_nempty = (r_count != '0);
    assign w_push   = rst_n && valid && ready;
    assign w_head   = r_mem[r_rd_ptr];
    // A pop is the only way into START, so it also restarts the bit timer.
    assign w_pop    = w_nempty && ((r_state == IDLE) || (r_state == STOP && w_tick));

    assign tx   = r_tx;
    assign busy = (r_state != IDLE) || w_nempty;

    uart_baud_gen #(
        .CLKS_PER_BIT(CPB)
    ) u_baud (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_restart(w_pop),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_state <= START;
                        r_tx    <= 1'b0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state <= DATA;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit == LAST_BIT) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_state <= START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning the line bit rate in bit/s.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of byte entries in the transmit FIFO (power of 2, >=2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock, all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port data, input, 8 bits: the byte offered for transmission.
REQ-007 The block SHALL have port valid, input, 1 bit: data is offered this cycle.
REQ-008 The block SHALL have port ready, output, 1 bit: the FIFO can accept a byte this cycle.
REQ-009 The block SHALL have port tx, output, 1 bit: the serial line, idle high.
REQ-010 The block SHALL have port busy, output, 1 bit: a frame is on the line or the FIFO is non-empty.

Function
REQ-011 CLKS_PER_BIT SHALL equal CLK_FREQ/BAUD (integer division, 434 at defaults); elaboration SHALL fail if it is below 2.
REQ-012 A byte SHALL be accepted into the FIFO on a rising edge where valid=1 and ready=1; valid while ready=0 SHALL be ignored and the source holds data.
REQ-013 ready SHALL equal (FIFO count < FIFO_DEPTH), derived from registered count only.
REQ-014 The FIFO SHALL preserve order, wrap read/write pointers modulo FIFO_DEPTH, and allow push and pop in the same cycle (count unchanged).
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP; each bit period SHALL last exactly CLKS_PER_BIT cycles.
REQ-016 IDLE: tx=1; if count>0, pop one byte into the shift register and enter START on the next edge.
REQ-017 START: tx=0 for one bit period, then go to DATA with bit index 0.
REQ-018 DATA: tx = shift register bit, LSB first, 8 bit periods, then go to STOP.
REQ-019 STOP: tx=1 for one bit period; at its last cycle, if count>0 pop and go directly to START (no idle gap), else go to IDLE.
REQ-020 A frame SHALL occupy exactly 10*CLKS_PER_BIT cycles on tx; tx SHALL be a registered output, glitch-free.
REQ-021 Latency from acceptance into an empty FIFO with FSM in IDLE to tx falling SHALL be 2 cycles.
REQ-022 busy SHALL be 1 whenever state != IDLE or count > 0, else 0.

Reset
REQ-023 While rst_n=0 at a rising edge: tx=1, ready=1, busy=0, state=IDLE, FIFO count and pointers=0, bit and baud counters=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame (tx=1 from the next edge) and discard all queued bytes; no partial frame resumes after release.
REQ-025 data and valid SHALL be ignored while rst_n=0.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state enum (IDLE, START, DATA, STOP), the data-width constant 8, and the CLKS_PER_BIT computation function, shared with uart_rx.
REQ-027 A sub-module uart_baud_gen SHALL produce a one-cycle bit-period tick, restarted by uart_tx on every START entry.
REQ-028 The FIFO SHALL be inline in uart_tx (register array plus pointers); no vendor primitives.

Verification (CLK_FREQ=1000, BAUD=100, CLKS_PER_BIT=10, FIFO_DEPTH=4)
REQ-029 Push 0xA5 once when idle -> tx low 10 cycles, data bits 1,0,1,0,0,1,0,1 each 10 cycles, stop high 10 cycles; busy falls 100 cycles after tx falls.
REQ-030 Push 0x00 then 0xFF back-to-back -> 200 contiguous frame cycles, the second start bit immediately following the first stop bit, no extra idle cycle.
REQ-031 Push 0x11..0x16 on consecutive cycles -> ready falls after 0x15 is accepted; 0x16 is accepted the cycle after the pop that starts frame 2; all six bytes are transmitted in order.
REQ-032 Hold valid=1 with 0x77 while ready=0 for 20 cycles -> exactly one 0x77 frame is sent once the byte is accepted, with no duplicates.
REQ-033 rst_n low for 1 cycle during data bit 3 with 2 bytes queued -> next edge tx=1, busy=0, ready=1; no further frames until a new push.
